beat_tone_player: RTL and testbench

//  Sequencer and audio back-end for the beat-to-tone song lookup.
//  - Drives the 8-bit beat index (one step per 1/4 beat) to the combinational song table.
//  - Receives the 32-bit tone frequency (Hz) and synthesizes a 1-bit square wave for the speaker/PWM pin.
//  - Provides start/stop/pause/loop control and a done pulse.

---
 rtl/beat_tone_player.sv | 173 +++++++++++++++++
 tb/tb_beat_tone_player.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_tone_player.sv
// -----------------------------------------------------------------------------
// beat_tone_player
//
// Sequencer and audio back-end for a beat-to-tone song lookup. The block steps
// an 8-bit beat index (one step per quarter beat) that drives an external
// combinational song table. It takes the returned tone frequency in Hz and turns
// it into a 1-bit square wave using a numerically controlled oscillator.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   1-cycle pulse: (re)start the song from beat 0
//   stop       in   1   1-cycle pulse: abort playback, return to IDLE (wins over start)
//   pause      in   1   level: freeze playback while high
//   loop_en    in   1   level: wrap to beat 0 after LAST_BEAT instead of ending
//   tone_i     in   32  tone frequency in Hz for beat_num_o
//   beat_num_o out  8   current beat index to the song table
//   audio_o    out  1   square-wave audio output
//   playing_o  out  1   high in PLAY or PAUSED
//   done_o     out  1   1-cycle pulse when the song ends without looping
// -----------------------------------------------------------------------------
module beat_tone_player #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BEATS_PER_SEC = 8,
    parameter int LAST_BEAT     = 255,
    parameter int SILENT_MIN    = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        loop_en,
    input  logic [31:0] tone_i,
    output logic [7:0]  beat_num_o,
    output logic        audio_o,
    output logic        playing_o,
    output logic        done_o
);

    localparam int TICKS  = CLK_FREQ / BEATS_PER_SEC;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
    localparam logic [7:0]        BEAT_LAST = 8'(LAST_BEAT);
    localparam logic [32:0]       HALF      = 33'(CLK_FREQ / 2);
    localparam logic [31:0]       SILENT    = 32'(SILENT_MIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_beat;
    logic [TICK_W-1:0]   r_tick;
    logic [31:0]         r_acc;
    logic [31:0]         r_tone_q;
    logic                r_audio;
    logic                r_playing;
    logic                r_done;

    logic                w_silent;
    logic [32:0]         w_sum;
    logic                w_tick_wrap;
    logic                w_song_end;

    // The accumulator stays below HALF, but tone_q may be as large as
    // SILENT_MIN-1, so the sum gets one extra bit to avoid wrap-around.
    assign w_silent    = (r_tone_q == 32'd0) || (r_tone_q >= SILENT);
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_tone_q};
    assign w_tick_wrap = (r_tick == TICK_LAST);
    assign w_song_end  = w_tick_wrap && (r_beat == BEAT_LAST) && !loop_en;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is state, so all use non-blocking
        // assignments; when one register is assigned twice on the same edge,
        // the later assignment is the one that takes effect.
        if (!rst_n) begin
            r_state   <= IDLE;
            r_beat    <= 8'd0;
            r_tick    <= '0;
            r_acc     <= 32'd0;
            r_tone_q  <= 32'd0;
            r_audio   <= 1'b0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tone_q <= tone_i;
            r_done   <= 1'b0;

            if (stop) begin
                r_state   <= IDLE;
                r_playing <= 1'b0;
                r_beat    <= 8'd0;
                r_tick    <= '0;
                r_acc     <= 32'd0;
                r_audio   <= 1'b0;
            end else if (start) begin
                r_state   <= PLAY;
                r_playing <= 1'b1;
                r_beat    <= 8'd0;
                r_tick    <= '0;
                r_acc     <= 32'd0;
                r_audio   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_acc   <= 32'd0;
                        r_audio <= 1'b0;
                    end

                    PLAY, PAUSED: begin
                        if (pause) begin
                            // Everything except tone_q holds while paused.
                            r_state <= PAUSED;
                        end else begin
                            // Releasing pause resumes on the same edge, so a
                            // pause of N cycles delays the song by exactly N.
                            r_state <= PLAY;

                            if (w_silent) begin
                                r_acc   <= 32'd0;
                                r_audio <= 1'b0;
                            end else if (w_sum >= HALF) begin
                                r_acc   <= 32'(w_sum - HALF);
                                r_audio <= ~r_audio;
                            end else begin
                                r_acc   <= w_sum[31:0];
                            end

                            if (w_tick_wrap) begin
                                r_tick <= '0;
                                if (r_beat != BEAT_LAST) begin
                                    r_beat <= r_beat + 8'd1;
                                end else begin
                                    r_beat <= 8'd0;
                                end
                            end else begin
                                r_tick <= r_tick + 1'b1;
                            end

                            // End of song overrides the oscillator update above.
                            if (w_song_end) begin
                                r_state   <= IDLE;
                                r_playing <= 1'b0;
                                r_done    <= 1'b1;
                                r_acc     <= 32'd0;
                                r_audio   <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        r_state   <= IDLE;
                        r_playing <= 1'b0;
                        r_beat    <= 8'd0;
                        r_tick    <= '0;
                        r_acc     <= 32'd0;
                        r_audio   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign beat_num_o = r_beat;
    assign audio_o    = r_audio;
    assign playing_o  = r_playing;
    assign done_o     = r_done;

endmodule

// File: tb/tb_beat_tone_player.sv
// -----------------------------------------------------------------------------
// tb_beat_tone_player
//
// Directed bench for beat_tone_player with CLK_FREQ=1000, BEATS_PER_SEC=10
// (100 clocks per beat step), LAST_BEAT=3, SILENT_MIN=400 (HALF=500).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// "Edge k" counts rising edges after the edge that captured the start pulse.
// -----------------------------------------------------------------------------
module tb_beat_tone_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop_en = 1'b0;
    logic [31:0] tone_i = 32'd0;
    logic [7:0]  beat_num_o;
    logic        audio_o;
    logic        playing_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    beat_tone_player #(
        .CLK_FREQ      (1000),
        .BEATS_PER_SEC (10),
        .LAST_BEAT     (3),
        .SILENT_MIN    (400)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop_en    (loop_en),
        .tone_i     (tone_i),
        .beat_num_o (beat_num_o),
        .audio_o    (audio_o),
        .playing_o  (playing_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tone_i = 32'd100;
        repeat (3) tick();
        n_checks++;
        if ({beat_num_o, audio_o, playing_o, done_o} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: beat=%0d audio=%b playing=%b done=%b, expected all 0",
                     beat_num_o, audio_o, playing_o, done_o);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (playing_o !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: playing=%b expected 0", playing_o);
        end
    endtask

    // tone 100 Hz: acc reaches 500 every 5 edges, so audio = (k/5)%2.
    task automatic test_play_beats();
        logic [7:0] exp_beat;
        logic       exp_audio;
        loop_en = 1'b0;
        tone_i  = 32'd100;
        start_song();
        for (int k = 1; k <= 399; k++) begin
            tick();
            exp_beat  = 8'(k / 100);
            exp_audio = ((k / 5) % 2) == 1;
            n_checks++;
            if (beat_num_o !== exp_beat || audio_o !== exp_audio ||
                playing_o !== 1'b1 || done_o !== 1'b0) begin
                n_errors++;
                $display("FAIL play_k%0d: beat=%0d audio=%b playing=%b done=%b, expected beat=%0d audio=%b playing=1 done=0",
                         k, beat_num_o, audio_o, playing_o, done_o, exp_beat, exp_audio);
            end
        end
    endtask

    task automatic test_song_end();
        logic [7:0] exp_beat;
        tick();   // edge 400: beat 3 wraps without loop
        n_checks++;
        if (done_o !== 1'b1 || playing_o !== 1'b0 || beat_num_o !== 8'd0 || audio_o !== 1'b0) begin
            n_errors++;
            $display("FAIL song_end: done=%b playing=%b beat=%0d audio=%b, expected done=1 playing=0 beat=0 audio=0",
                     done_o, playing_o, beat_num_o, audio_o);
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0 || playing_o !== 1'b0) begin
            n_errors++;
            $display("FAIL done_one_cycle: done=%b playing=%b, expected 0 0", done_o, playing_o);
        end
        loop_en = 1'b1;
        start_song();
        for (int k = 1; k <= 420; k++) begin
            tick();
            exp_beat = 8'((k / 100) % 4);
            n_checks++;
            if (done_o !== 1'b0 || playing_o !== 1'b1 || beat_num_o !== exp_beat) begin
                n_errors++;
                $display("FAIL loop_k%0d: done=%b playing=%b beat=%0d, expected done=0 playing=1 beat=%0d",
                         k, done_o, playing_o, beat_num_o, exp_beat);
            end
        end
    endtask

    task automatic test_silence();
        logic [10:0] pat;
        loop_en = 1'b1;
        tone_i  = 32'd100;
        start_song();
        repeat (7) tick();
        n_checks++;
        if (audio_o !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_silence_high: audio=%b expected 1", audio_o);
        end
        tone_i = 32'd20000;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (audio_o !== 1'b0) begin
                n_errors++;
                $display("FAIL silent_20000_%0d: audio=%b expected 0", i, audio_o);
            end
            tick();
        end
        tone_i = 32'd100;
        repeat (8) tick();
        n_checks++;
        if (audio_o !== 1'b1) begin
            n_errors++;
            $display("FAIL resume_100: audio=%b expected 1", audio_o);
        end
        tone_i = 32'd0;
        repeat (2) tick();
        n_checks++;
        if (audio_o !== 1'b0) begin
            n_errors++;
            $display("FAIL silent_zero: audio=%b expected 0", audio_o);
        end
        // 300 Hz from acc=0: edges 1..11 give 0,0,1,1,0,1,1,0,0,1,0 (bit i-1).
        pat = 11'b010_0110_1100;
        tone_i = 32'd300;
        for (int i = 1; i <= 11; i++) begin
            tick();
            n_checks++;
            if (audio_o !== pat[i-1]) begin
                n_errors++;
                $display("FAIL tone300_edge%0d: audio=%b expected %b", i, audio_o, pat[i-1]);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] exp_beat;
        logic       exp_audio;
        loop_en = 1'b1;
        tone_i  = 32'd100;
        start_song();
        repeat (27) tick();
        pause = 1'b1;
        for (int i = 0; i < 37; i++) begin
            tick();
            n_checks++;
            if (beat_num_o !== 8'd0 || audio_o !== 1'b1 || playing_o !== 1'b1) begin
                n_errors++;
                $display("FAIL paused_%0d: beat=%0d audio=%b playing=%b, expected beat=0 audio=1 playing=1",
                         i, beat_num_o, audio_o, playing_o);
            end
        end
        pause = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            tick();
            exp_beat  = 8'((27 + j) / 100);
            exp_audio = (((27 + j) / 5) % 2) == 1;
            n_checks++;
            if (beat_num_o !== exp_beat || audio_o !== exp_audio) begin
                n_errors++;
                $display("FAIL resume_j%0d: beat=%0d audio=%b, expected beat=%0d audio=%b",
                         j, beat_num_o, audio_o, exp_beat, exp_audio);
            end
        end
    endtask

    task automatic test_start_stop();
        loop_en = 1'b1;
        tone_i  = 32'd100;
        start_song();
        repeat (57) tick();
        n_checks++;
        if (audio_o !== 1'b1 || playing_o !== 1'b1) begin
            n_errors++;
            $display("FAIL before_stop: audio=%b playing=%b expected 1 1", audio_o, playing_o);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (playing_o !== 1'b0 || beat_num_o !== 8'd0 || audio_o !== 1'b0 || done_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_wins: playing=%b beat=%0d audio=%b done=%b, expected all 0",
                     playing_o, beat_num_o, audio_o, done_o);
        end
        tick();
        n_checks++;
        if (playing_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stays_idle: playing=%b expected 0", playing_o);
        end
        start_song();
        repeat (250) tick();
        n_checks++;
        if (beat_num_o !== 8'd2) begin
            n_errors++;
            $display("FAIL at_beat2: beat=%0d expected 2", beat_num_o);
        end
        start_song();
        n_checks++;
        if (beat_num_o !== 8'd0 || playing_o !== 1'b1 || audio_o !== 1'b0) begin
            n_errors++;
            $display("FAIL restart: beat=%0d playing=%b audio=%b, expected beat=0 playing=1 audio=0",
                     beat_num_o, playing_o, audio_o);
        end
    endtask

    task automatic test_async_reset();
        loop_en = 1'b1;
        tone_i  = 32'd100;
        start_song();
        repeat (157) tick();
        n_checks++;
        if (beat_num_o !== 8'd1 || audio_o !== 1'b1) begin
            n_errors++;
            $display("FAIL before_reset: beat=%0d audio=%b expected 1 1", beat_num_o, audio_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({beat_num_o, audio_o, playing_o, done_o} !== 11'd0) begin
            n_errors++;
            $display("FAIL async_reset: beat=%0d audio=%b playing=%b done=%b, expected all 0",
                     beat_num_o, audio_o, playing_o, done_o);
        end
        repeat (2) tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (playing_o !== 1'b0 || beat_num_o !== 8'd0 || audio_o !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_wait_%0d: playing=%b beat=%0d audio=%b, expected 0 0 0",
                         i, playing_o, beat_num_o, audio_o);
            end
        end
        start_song();
        repeat (5) tick();
        n_checks++;
        if (playing_o !== 1'b1 || audio_o !== 1'b1) begin
            n_errors++;
            $display("FAIL start_after_reset: playing=%b audio=%b expected 1 1", playing_o, audio_o);
        end
    endtask

    initial begin
        test_reset();
        test_play_beats();
        test_song_end();
        test_silence();
        test_pause();
        test_start_stop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
